conv2d_engine: RTL
==================

Name: conv2d_engine

Overview:
Convolution stage that consumes the image and weight buffers filled by the CNN memory block. It writes one layer's feature map into the output buffer. It runs one valid-padding, stride-1 2-D convolution with signed 8-bit operands and wide accumulation. The result is requantised by arithmetic shift and saturated to 8 bits. The host (or layer sequencer) pulses start once both input and weight buffers report loaded; done triggers the next layer.

Parameters:
IN_W, 100, input feature-map width
IN_H, 100, input feature-map height
IN_CH, 1, input channels
OUT_CH, 16, output channels (filters)
K, 5, square kernel size
SHIFT, 7, requantisation right-shift amount
ACC_W, 26, accumulator width (must hold 16 + clog2(IN_CH*K*K) bits)
AW_IN, 14, input buffer address width
AW_W, 15, weight buffer address width
AW_OUT, 18, output buffer address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a layer pass when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final output write
in_addr  out  AW_IN  input buffer read address
in_data  in  8  signed activation, valid one cycle after in_addr
w_addr  out  AW_W  weight buffer read address
w_data  in  8  signed weight, valid one cycle after w_addr
out_addr  out  AW_OUT  output buffer write address
out_data  out  8  signed result
out_we  out  1  output write strobe, one cycle per output element

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, out_we = 0; all addresses, out_data, counters and accumulator = 0.
- Derived sizes: OH = IN_H-K+1, OW = IN_W-K+1, TAPS = IN_CH*K*K.
- Loop order, outer to inner: oc, oy, ox, then ic, ky, kx.
- in_addr = ic*IN_H*IN_W + (oy+ky)*IN_W + (ox+kx).
- w_addr = ((oc*IN_CH+ic)*K+ky)*K+kx.
- out_addr = oc*OH*OW + oy*OW + ox.
- Address generation uses incremental counters, not multipliers.
- States:
  - IDLE: start accepted only here; goes to RUN next cycle.
  - RUN: issues one tap address pair per cycle for TAPS cycles; goes to DRAIN.
  - DRAIN: 2 cycles while the pipeline empties; goes to WRITE.
  - WRITE: out_we = 1 for exactly one cycle with the result. Goes to RUN at the next pixel, or to DONE after the last pixel.
  - DONE: done = 1 for one cycle; goes to IDLE.
- Pipeline: stage 0 issues addresses; stage 1 registers the RAM data; stage 2 registers the 16-bit signed product; stage 3 accumulates. The accumulator clears on the first tap of each pixel.
- Timing:
  - Per-pixel cost is TAPS+3 cycles, the WRITE cycle included.
  - The first RUN cycle is 1 cycle after start.
  - done asserts on the cycle after the final WRITE.
  - Total latency from start to done is 1 + OUT_CH*OH*OW*(TAPS+3) cycles.
- Requantisation:
  - r = acc >>> SHIFT (arithmetic shift, floor toward negative infinity).
  - Saturate r to [-128, 127].
  - out_data holds its value between writes.
- busy = 1 in RUN, DRAIN and WRITE; busy = 0 in IDLE and DONE.
- start is ignored while busy, and in the DONE cycle.
- Reset mid-run aborts immediately; the next start restarts at pixel 0 with oc = 0.
- Any other in_data/w_data values are don't-care.

Optional Feature:
- CONV2D_RELU_EN defined: after saturation, negative results are forced to 0, so out_data is in [0, 127].
- Undefined: signed saturated result is passed through unchanged.
- Timing is identical either way.

Decomposition:
- Package cnn_pkg holds:
  - typedefs act_t (logic signed [7:0]), prod_t (signed [15:0]);
  - the state enum conv_state_t;
  - function sat8() for shift-and-saturate.
- Sub-module conv_addr_gen: the nested counters and the three address outputs, with tap_first, tap_last and pixel_last flags.
- MAC pipeline and FSM stay in conv2d_engine.

Test Plan:
- Data path: IN_W=IN_H=4, K=3, IN_CH=OUT_CH=1, SHIFT=0, all activations and weights = 1, start.
  - 4 writes at out_addr 0,1,2,3, each out_data = 9.
  - done exactly 49 cycles after start; busy low afterwards.
- Saturation: same config, activations = 127, weights = 127 -> every out_data = 127. Weights = -127 -> every out_data = -128, or 0 with CONV2D_RELU_EN.
- Shift rounding: SHIFT=2, weights all 1 then all -1 -> out_data = 2 and -3 respectively (floor).
- Address order: IN_CH=2, OUT_CH=2, activation = address LSBs, weights from a ramp.
  - Scoreboard checks every in_addr/w_addr against the formulas.
  - out_addr sequence is 0..7.
- Handshake: pulse start at cycle 5 of a run and again in the done cycle -> both ignored; a single pass occurs; exactly one done pulse.
- Reset mid-run: assert reset_n=0 during the second pixel -> busy, out_we and done drop to 0 immediately. A new start yields correct outputs from out_addr 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN convolution stage.
//   act_t        : signed 8-bit activation / weight / result
//   prod_t       : signed 16-bit product of two act_t
//   conv_state_t : conv2d_engine FSM states (encodings fixed by S_* constants)
//   sat8()       : arithmetic right shift then saturate to [-128, 127]
package cnn_pkg;

  typedef logic signed [7:0]  act_t;
  typedef logic signed [15:0] prod_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } conv_state_t;

  // Floor division by 2**shift (>>> on a signed value), then clamp.
  function automatic act_t sat8(input logic signed [63:0] acc, input int unsigned shift);
    logic signed [63:0] r;
    r = acc >>> shift;
    if (r > 64'sd127)       return 8'sd127;
    else if (r < -64'sd128) return -8'sd128;
    else                    return r[7:0];
  endfunction

endpackage

// File: rtl/conv2d_engine_if.sv
// Bus bundle between conv2d_engine and its host / buffers.
//   start, busy, done         : layer handshake
//   in_addr / in_data         : input buffer read (data one cycle after addr)
//   w_addr / w_data           : weight buffer read (data one cycle after addr)
//   out_addr/out_data/out_we  : output buffer write
// master = engine side, slave = host/memory side.
interface conv2d_engine_if #(
  parameter int AW_IN  = 14,
  parameter int AW_W   = 15,
  parameter int AW_OUT = 18
);
  import cnn_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [AW_IN-1:0]  in_addr;
  act_t              in_data;
  logic [AW_W-1:0]   w_addr;
  act_t              w_data;
  logic [AW_OUT-1:0] out_addr;
  act_t              out_data;
  logic              out_we;

  modport master (
    input  start, in_data, w_data,
    output busy, done, in_addr, w_addr, out_addr, out_data, out_we
  );

  modport slave (
    output start, in_data, w_data,
    input  busy, done, in_addr, w_addr, out_addr, out_data, out_we
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Nested loop counters and address generation for conv2d_engine.
// Loop order outer->inner: oc, oy, ox, ic, ky, kx. All addresses are
// maintained incrementally (no multipliers).
//   clear      : return every counter/address to pixel 0, tap 0
//   tap_step   : advance to the next tap of the current pixel (held at last tap)
//   pix_step   : advance to tap 0 of the next pixel
//   in_addr, w_addr, out_addr : buffer addresses for the current tap/pixel
//   tap_first, tap_last, pixel_last : position flags
module conv_addr_gen #(
  parameter int IN_W   = 100,
  parameter int IN_H   = 100,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 16,
  parameter int K      = 5,
  parameter int AW_IN  = 14,
  parameter int AW_W   = 15,
  parameter int AW_OUT = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              tap_step,
  input  logic              pix_step,
  output logic [AW_IN-1:0]  in_addr,
  output logic [AW_W-1:0]   w_addr,
  output logic [AW_OUT-1:0] out_addr,
  output logic              tap_first,
  output logic              tap_last,
  output logic              pixel_last
);
  localparam int OH   = IN_H - K + 1;
  localparam int OW   = IN_W - K + 1;
  localparam int TAPS = IN_CH * K * K;
  localparam int CW   = 16;

  // in_addr jumps: kx wrap -> next row; ky wrap -> next channel plane;
  // ox wrap -> next output row; w_addr jumps one filter per oc.
  localparam logic [AW_IN-1:0] D_KY = AW_IN'(IN_W - K + 1);
  localparam logic [AW_IN-1:0] D_IC = AW_IN'(IN_H * IN_W - (K - 1) * IN_W - (K - 1));
  localparam logic [AW_IN-1:0] D_OY = AW_IN'(K);
  localparam logic [AW_W-1:0]  D_OC = AW_W'(TAPS);

  logic [CW-1:0] kx, ky, ic, ox, oy, oc;
  logic [CW-1:0] ox_nx, oy_nx, oc_nx;
  logic [AW_IN-1:0] in_base, in_base_nx;
  logic [AW_W-1:0]  w_base, w_base_nx;
  logic kx_end, ky_end, ic_end, ox_end, oy_end, oc_end;

  assign kx_end = (kx == CW'(K - 1));
  assign ky_end = (ky == CW'(K - 1));
  assign ic_end = (ic == CW'(IN_CH - 1));
  assign ox_end = (ox == CW'(OW - 1));
  assign oy_end = (oy == CW'(OH - 1));
  assign oc_end = (oc == CW'(OUT_CH - 1));

  assign tap_first  = (kx == '0) && (ky == '0) && (ic == '0);
  assign tap_last   = kx_end && ky_end && ic_end;
  assign pixel_last = ox_end && oy_end && oc_end;

  always_comb begin
    ox_nx      = ox + 1'b1;
    oy_nx      = oy;
    oc_nx      = oc;
    in_base_nx = in_base + 1'b1;
    w_base_nx  = w_base;
    if (ox_end) begin
      ox_nx      = '0;
      oy_nx      = oy + 1'b1;
      in_base_nx = in_base + D_OY;
      if (oy_end) begin
        oy_nx      = '0;
        oc_nx      = oc + 1'b1;
        in_base_nx = '0;
        w_base_nx  = w_base + D_OC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kx <= '0; ky <= '0; ic <= '0; ox <= '0; oy <= '0; oc <= '0;
      in_base <= '0; w_base <= '0;
      in_addr <= '0; w_addr <= '0; out_addr <= '0;
    end else if (clear) begin
      kx <= '0; ky <= '0; ic <= '0; ox <= '0; oy <= '0; oc <= '0;
      in_base <= '0; w_base <= '0;
      in_addr <= '0; w_addr <= '0; out_addr <= '0;
    end else if (pix_step) begin
      kx <= '0; ky <= '0; ic <= '0;
      ox <= ox_nx; oy <= oy_nx; oc <= oc_nx;
      in_base  <= in_base_nx;
      w_base   <= w_base_nx;
      in_addr  <= in_base_nx;
      w_addr   <= w_base_nx;
      out_addr <= out_addr + 1'b1;
    end else if (tap_step && !tap_last) begin
      w_addr <= w_addr + 1'b1;
      if (!kx_end) begin
        kx      <= kx + 1'b1;
        in_addr <= in_addr + 1'b1;
      end else if (!ky_end) begin
        kx      <= '0;
        ky      <= ky + 1'b1;
        in_addr <= in_addr + D_KY;
      end else begin
        kx      <= '0;
        ky      <= '0;
        ic      <= ic + 1'b1;
        in_addr <= in_addr + D_IC;
      end
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// Valid-padding, stride-1 2-D convolution engine (signed 8-bit operands,
// ACC_W-bit accumulation, shift-and-saturate requantisation).
// Ports: clk, reset_n (async active-low), bus (conv2d_engine_if.master:
// start/busy/done handshake, input/weight buffer reads, output writes).
// Optional macro CONV2D_RELU_EN: clamp negative results to 0.
// Per pixel: TAPS RUN cycles, 2 DRAIN cycles, 1 WRITE cycle.
module conv2d_engine
  import cnn_pkg::*;
#(
  parameter int IN_W   = 100,
  parameter int IN_H   = 100,
  parameter int IN_CH  = 1,
  parameter int OUT_CH = 16,
  parameter int K      = 5,
  parameter int SHIFT  = 7,
  parameter int ACC_W  = 26,
  parameter int AW_IN  = 14,
  parameter int AW_W   = 15,
  parameter int AW_OUT = 18
) (
  input  logic            clk,
  input  logic            reset_n,
  conv2d_engine_if.master bus
);
  conv_state_t state;
  logic        drain_last;
  logic        run, tap_first, tap_last, pixel_last;
  logic        first_d1, first_d2, vld_d1, vld_d2;
  prod_t       prod;
  logic signed [ACC_W-1:0] acc, acc_nx;
  act_t        q_sat, q_out, out_q;

  assign run = (state == ST_RUN);

  conv_addr_gen #(
    .IN_W(IN_W), .IN_H(IN_H), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .K(K),
    .AW_IN(AW_IN), .AW_W(AW_W), .AW_OUT(AW_OUT)
  ) u_addr (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     ((state == ST_IDLE) && bus.start),
    .tap_step  (run),
    .pix_step  ((state == ST_WRITE) && !pixel_last),
    .in_addr   (bus.in_addr),
    .w_addr    (bus.w_addr),
    .out_addr  (bus.out_addr),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .pixel_last(pixel_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      drain_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state <= ST_RUN;
        ST_RUN: begin
          drain_last <= 1'b0;
          if (tap_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_last <= 1'b1;
          if (drain_last) state <= ST_WRITE;
        end
        ST_WRITE: state <= pixel_last ? ST_DONE : ST_RUN;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Tap issued in cycle c: buffer data in c+1, product registered at end of
  // c+1, accumulated at end of c+2. For the last tap c+2 is the final DRAIN
  // cycle, so the result is registered straight from acc_nx into out_q and
  // is presented during WRITE.
  assign acc_nx = first_d2 ? ACC_W'(prod) : acc + ACC_W'(prod);

  always_comb begin
    q_sat = sat8(64'(acc_nx), SHIFT);
`ifdef CONV2D_RELU_EN
    q_out = q_sat[7] ? '0 : q_sat;
`else
    q_out = q_sat;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_d1 <= 1'b0;
      first_d2 <= 1'b0;
      vld_d1   <= 1'b0;
      vld_d2   <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      out_q    <= '0;
    end else begin
      first_d1 <= run && tap_first;
      vld_d1   <= run;
      first_d2 <= first_d1;
      vld_d2   <= vld_d1;
      prod     <= prod_t'(bus.in_data) * prod_t'(bus.w_data);
      if (vld_d2) acc <= acc_nx;
      if ((state == ST_DRAIN) && drain_last) out_q <= q_out;
    end
  end

  assign bus.busy     = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_WRITE);
  assign bus.done     = (state == ST_DONE);
  assign bus.out_we   = (state == ST_WRITE);
  assign bus.out_data = out_q;

endmodule
